// File: rtl/fic_apb_splitter.sv
// fic_apb_splitter: one APB requester fanned out to NUM_SLAVES APB completers.
// The slot is decoded from M_PADDR[SLOT_LSB +: SLOT_BITS], and the transfer is
// re-launched to that completer as a fresh SETUP/ACCESS pair. A completer that
// holds PREADY low for TIMEOUT_CYCLES ACCESS cycles is abandoned with an error.
//
// Ports
//   FIC_0_CLK, FAB_RESET_N              clock, async active-low reset
//   M_PADDR/M_PSEL/M_PENABLE/M_PWRITE/M_PWDATA   requester request (inputs)
//   M_PRDATA/M_PREADY/M_PSLVERR          requester response (registered)
//   S_PADDR/S_PSEL/S_PENABLE/S_PWRITE/S_PWDATA   completer request (registered)
//   S_PRDATA/S_PREADY/S_PSLVERR          completer response (inputs)
//   TIMEOUT_PULSE                        one-cycle flag on a forced timeout
module fic_apb_splitter #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SLOT_LSB       = 12,
  parameter int unsigned SLOT_BITS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             FIC_0_CLK,
  input  logic                             FAB_RESET_N,
  input  logic [31:0]                      M_PADDR,
  input  logic                             M_PSEL,
  input  logic                             M_PENABLE,
  input  logic                             M_PWRITE,
  input  logic [DATA_WIDTH-1:0]            M_PWDATA,
  output logic [DATA_WIDTH-1:0]            M_PRDATA,
  output logic                             M_PREADY,
  output logic                             M_PSLVERR,
  output logic [31:0]                      S_PADDR,
  output logic [NUM_SLAVES-1:0]            S_PSEL,
  output logic                             S_PENABLE,
  output logic                             S_PWRITE,
  output logic [DATA_WIDTH-1:0]            S_PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_PRDATA,
  input  logic [NUM_SLAVES-1:0]            S_PREADY,
  input  logic [NUM_SLAVES-1:0]            S_PSLVERR,
  output logic                             TIMEOUT_PULSE
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   m_prdata_q, m_prdata_d;
  logic                    m_pready_q, m_pready_d;
  logic                    m_pslverr_q, m_pslverr_d;
  logic [ADDR_W-1:0]       s_paddr_q, s_paddr_d;
  logic [NUM_SLAVES-1:0]   s_psel_q, s_psel_d;
  logic                    s_penable_q, s_penable_d;
  logic                    s_pwrite_q, s_pwrite_d;
  logic [DATA_WIDTH-1:0]   s_pwdata_q, s_pwdata_d;
  logic                    timeout_pulse_q, timeout_pulse_d;

  logic [SLOT_BITS-1:0]    slot;
  logic                    slot_ok;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    sel_ready;
  logic                    sel_err;

  // Slot decode straight from the requester address (used only in IDLE)
  assign slot    = M_PADDR[SLOT_LSB +: SLOT_BITS];
  assign slot_ok = (32'(slot) < NUM_SLAVES);

  always_comb begin
    dec_onehot = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (32'(slot) == k) dec_onehot[k] = 1'b1;
    end
  end

  // Response of the selected completer; the registered one-hot select masks
  // out every other slot so their PREADY/PSLVERR/PRDATA have no effect.
  always_comb begin
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (s_psel_q[k]) sel_rdata = sel_rdata | S_PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_ready = |(S_PREADY & s_psel_q);
  assign sel_err   = |(S_PSLVERR & s_psel_q);

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    m_prdata_d      = m_prdata_q;
    m_pslverr_d     = m_pslverr_q;
    s_paddr_d       = s_paddr_q;
    s_psel_d        = s_psel_q;
    s_pwrite_d      = s_pwrite_q;
    s_pwdata_d      = s_pwdata_q;
    timeout_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (M_PSEL && !M_PENABLE) begin
          s_paddr_d  = M_PADDR;
          s_pwrite_d = M_PWRITE;
          s_pwdata_d = M_PWDATA;
          if (slot_ok) begin
            state_d  = ST_SETUP;
            s_psel_d = dec_onehot;
          end else begin
            // Unmapped slot: answer directly, no completer is touched
            state_d     = ST_RESP;
            m_prdata_d  = '0;
            m_pslverr_d = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        // Ready wins over timeout when both land on the same cycle
        if (sel_ready) begin
          state_d     = ST_RESP;
          s_psel_d    = '0;
          cnt_d       = '0;
          m_prdata_d  = s_pwrite_q ? '0 : sel_rdata;
          m_pslverr_d = sel_err;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d         = ST_RESP;
          s_psel_d        = '0;
          cnt_d           = '0;
          m_prdata_d      = '0;
          m_pslverr_d     = 1'b1;
          timeout_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d  = ST_IDLE;
        s_psel_d = '0;
        cnt_d    = '0;
      end
    endcase

    s_penable_d = (state_d == ST_ACCESS);
    m_pready_d  = (state_d == ST_RESP);
  end

  // State and output registers
  always_ff @(posedge FIC_0_CLK or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      m_prdata_q      <= '0;
      m_pready_q      <= 1'b0;
      m_pslverr_q     <= 1'b0;
      s_paddr_q       <= '0;
      s_psel_q        <= '0;
      s_penable_q     <= 1'b0;
      s_pwrite_q      <= 1'b0;
      s_pwdata_q      <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      m_prdata_q      <= m_prdata_d;
      m_pready_q      <= m_pready_d;
      m_pslverr_q     <= m_pslverr_d;
      s_paddr_q       <= s_paddr_d;
      s_psel_q        <= s_psel_d;
      s_penable_q     <= s_penable_d;
      s_pwrite_q      <= s_pwrite_d;
      s_pwdata_q      <= s_pwdata_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign M_PRDATA      = m_prdata_q;
  assign M_PREADY      = m_pready_q;
  assign M_PSLVERR     = m_pslverr_q;
  assign S_PADDR       = s_paddr_q;
  assign S_PSEL        = s_psel_q;
  assign S_PENABLE     = s_penable_q;
  assign S_PWRITE      = s_pwrite_q;
  assign S_PWDATA      = s_pwdata_q;
  assign TIMEOUT_PULSE = timeout_pulse_q;

endmodule

// File: tb/tb_fic_apb_splitter.sv
// Testbench for fic_apb_splitter: directed vector table, hand sequences for
// reset/RESP corner cases, and random transfers checked against a model.
module tb_fic_apb_splitter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       M_PADDR;
  logic              M_PSEL, M_PENABLE, M_PWRITE;
  logic [DW-1:0]     M_PWDATA;
  logic [DW-1:0]     M_PRDATA;
  logic              M_PREADY, M_PSLVERR;
  logic [31:0]       S_PADDR;
  logic [NS-1:0]     S_PSEL;
  logic              S_PENABLE, S_PWRITE;
  logic [DW-1:0]     S_PWDATA;
  logic [NS*DW-1:0]  S_PRDATA;
  logic [NS-1:0]     S_PREADY, S_PSLVERR;
  logic              TIMEOUT_PULSE;

  always #5 clk = ~clk;

  fic_apb_splitter #(
    .NUM_SLAVES    (NS),
    .DATA_WIDTH    (DW),
    .SLOT_LSB      (12),
    .SLOT_BITS     (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .FIC_0_CLK    (clk),
    .FAB_RESET_N  (rst_n),
    .M_PADDR      (M_PADDR),
    .M_PSEL       (M_PSEL),
    .M_PENABLE    (M_PENABLE),
    .M_PWRITE     (M_PWRITE),
    .M_PWDATA     (M_PWDATA),
    .M_PRDATA     (M_PRDATA),
    .M_PREADY     (M_PREADY),
    .M_PSLVERR    (M_PSLVERR),
    .S_PADDR      (S_PADDR),
    .S_PSEL       (S_PSEL),
    .S_PENABLE    (S_PENABLE),
    .S_PWRITE     (S_PWRITE),
    .S_PWDATA     (S_PWDATA),
    .S_PRDATA     (S_PRDATA),
    .S_PREADY     (S_PREADY),
    .S_PSLVERR    (S_PSLVERR),
    .TIMEOUT_PULSE(TIMEOUT_PULSE)
  );

  // One transfer: stimulus plus expected requester-side result.
  // wt = ACCESS cycles the target holds PREADY low before raising it.
  typedef struct {
    logic [31:0]   addr;
    logic          wr;
    logic [31:0]   wdata;
    int            wt;
    logic [31:0]   rdata;
    logic          err;
    logic          drop;
    int            e_lat;
    logic [31:0]   e_data;
    logic          e_err;
    logic          e_to;
    logic [NS-1:0] e_psel;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Requester-visible outcome from the addressing and timeout rules
  function automatic void model(input logic [31:0] addr, input logic wr, input int wt,
                                input logic [31:0] rdata, input logic err,
                                output int lat, output logic [31:0] data,
                                output logic e_err, output logic to,
                                output logic [NS-1:0] psel);
    int slot;
    slot = int'(addr[15:12]);
    if (slot >= int'(NS)) begin
      lat = 1; data = '0; e_err = 1'b1; to = 1'b0; psel = '0;
    end else if (wt >= int'(TO)) begin
      lat = 2 + int'(TO); data = '0; e_err = 1'b1; to = 1'b1; psel = NS'(1 << slot);
    end else begin
      lat = 3 + wt; data = wr ? 32'h0 : rdata; e_err = err; to = 1'b0; psel = NS'(1 << slot);
    end
  endfunction

  // Drive one requester transfer and act as the completers; check the result
  task automatic run_txn(input string tag, input vec_t v);
    int n, acc, to_cnt, multi, tgt;
    logic seen, got_err;
    logic [31:0] got_data;
    logic [NS-1:0] psel_or;
    tgt = int'(v.addr[15:12]);
    for (int k = 0; k < int'(NS); k++) begin
      S_PRDATA[k*DW +: DW] = (k == tgt) ? v.rdata : (32'hDEAD_0000 | 32'(k));
      S_PREADY[k]          = (k != tgt);
      S_PSLVERR[k]         = (k != tgt) ? 1'b1 : v.err;
    end
    @(negedge clk);
    M_PADDR = v.addr; M_PWRITE = v.wr; M_PWDATA = v.wdata;
    M_PSEL = 1'b1; M_PENABLE = 1'b0;
    n = 0; acc = 0; to_cnt = 0; multi = 0; seen = 1'b0;
    got_err = 1'b0; got_data = '0; psel_or = '0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      M_PENABLE = !v.drop;
      M_PSEL    = !v.drop;
      if (TIMEOUT_PULSE) to_cnt++;
      psel_or = psel_or | S_PSEL;
      if ($countones(S_PSEL) > 1) multi++;
      if (n == 1 && v.e_psel != '0) begin
        chk({tag, " setup_psel"},    32'(S_PSEL), 32'(v.e_psel));
        chk({tag, " setup_penable"}, 32'(S_PENABLE), 32'h0);
        chk({tag, " setup_paddr"},   S_PADDR, v.addr);
        chk({tag, " setup_pwrite"},  32'(S_PWRITE), 32'(v.wr));
        chk({tag, " setup_pwdata"},  S_PWDATA, v.wdata);
      end
      if (M_PREADY) begin
        seen = 1'b1;
        got_data = M_PRDATA;
        got_err  = M_PSLVERR;
        chk({tag, " resp_psel"}, 32'({S_PSEL, S_PENABLE}), 32'h0);
      end else if (S_PENABLE && ((S_PSEL & v.e_psel) != '0)) begin
        acc++;
        if (acc > v.wt) S_PREADY = S_PREADY | v.e_psel;
      end
    end
    chk({tag, " latency"},   32'(n), 32'(v.e_lat));
    chk({tag, " prdata"},    got_data, v.e_data);
    chk({tag, " pslverr"},   32'(got_err), 32'(v.e_err));
    chk({tag, " psel_seen"}, 32'(psel_or), 32'(v.e_psel));
    chk({tag, " onehot"},    32'(multi), 32'h0);
    M_PSEL = 1'b0; M_PENABLE = 1'b0; S_PREADY = '0; S_PSLVERR = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (TIMEOUT_PULSE) to_cnt++;
      chk({tag, " hold_pready"}, 32'(M_PREADY), 32'h0);
      chk({tag, " hold_prdata"}, M_PRDATA, v.e_data);
    end
    chk({tag, " timeout_pulses"}, 32'(to_cnt), 32'(v.e_to));
  endtask

  vec_t tbl[11];
  vec_t r;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NS-1:0] pacc;
    logic racc;
    int lat;
    logic [31:0] d;
    logic e, t;
    logic [NS-1:0] ps;

    //        addr          wr    wdata          wt  rdata          err   drop  lat data           err   to    psel
    tbl[0]  = '{32'h0000_2004, 1'b0, 32'h0,         0, 32'hA5A5_1234, 1'b0, 1'b0, 3,  32'hA5A5_1234, 1'b0, 1'b0, 4'b0100};
    tbl[1]  = '{32'h0000_1010, 1'b1, 32'hCAFE_F00D, 5, 32'h1234_5678, 1'b1, 1'b0, 8,  32'h0,         1'b1, 1'b0, 4'b0010};
    tbl[2]  = '{32'h0000_7000, 1'b0, 32'h0,         0, 32'h5555_5555, 1'b0, 1'b0, 1,  32'h0,         1'b1, 1'b0, 4'b0000};
    tbl[3]  = '{32'h0000_0040, 1'b0, 32'h0,        99, 32'h7777_7777, 1'b0, 1'b0, 18, 32'h0,         1'b1, 1'b1, 4'b0001};
    tbl[4]  = '{32'h0000_3FFC, 1'b0, 32'h0,         0, 32'h0BAD_BEEF, 1'b0, 1'b0, 3,  32'h0BAD_BEEF, 1'b0, 1'b0, 4'b1000};
    tbl[5]  = '{32'h0000_1000, 1'b0, 32'h0,        15, 32'h1111_2222, 1'b0, 1'b0, 18, 32'h1111_2222, 1'b0, 1'b0, 4'b0010};
    tbl[6]  = '{32'h0000_2000, 1'b0, 32'h0,        16, 32'h3333_4444, 1'b0, 1'b0, 18, 32'h0,         1'b1, 1'b1, 4'b0100};
    tbl[7]  = '{32'h0000_F000, 1'b1, 32'hFFFF_FFFF, 0, 32'h0,         1'b0, 1'b0, 1,  32'h0,         1'b1, 1'b0, 4'b0000};
    tbl[8]  = '{32'h0000_0008, 1'b1, 32'h0102_0304, 1, 32'h9999_8888, 1'b0, 1'b0, 4,  32'h0,         1'b0, 1'b0, 4'b0001};
    tbl[9]  = '{32'h0000_3100, 1'b0, 32'h0,         2, 32'h8765_4321, 1'b1, 1'b1, 5,  32'h8765_4321, 1'b1, 1'b0, 4'b1000};
    tbl[10] = '{32'h1234_5000, 1'b0, 32'h0,         0, 32'h4444_4444, 1'b0, 1'b0, 1,  32'h0,         1'b1, 1'b0, 4'b0000};

    rst_n = 1'b0;
    M_PADDR = '0; M_PSEL = 1'b0; M_PENABLE = 1'b0; M_PWRITE = 1'b0; M_PWDATA = '0;
    S_PRDATA = '0; S_PREADY = '0; S_PSLVERR = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst prdata", M_PRDATA, 32'h0);
    chk("rst ctrl", 32'({M_PREADY, M_PSLVERR, S_PSEL, S_PENABLE, S_PWRITE, TIMEOUT_PULSE}), 32'h0);
    chk("rst paddr", S_PADDR, 32'h0);
    chk("rst pwdata", S_PWDATA, 32'h0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // A requester SETUP presented during RESP must be ignored
    S_PREADY = '0; S_PSLVERR = '0;
    @(negedge clk);
    M_PADDR = 32'h0000_7000; M_PWRITE = 1'b0; M_PSEL = 1'b1; M_PENABLE = 1'b0;
    @(negedge clk);
    chk("respacc pready", 32'(M_PREADY), 32'h1);
    M_PADDR = 32'h0000_2000; M_PSEL = 1'b1; M_PENABLE = 1'b0;
    @(negedge clk);
    M_PSEL = 1'b0;
    pacc = S_PSEL; racc = M_PREADY;
    repeat (2) begin
      @(negedge clk);
      pacc = pacc | S_PSEL;
      racc = racc | M_PREADY;
    end
    chk("respacc psel", 32'(pacc), 32'h0);
    chk("respacc pready_after", 32'(racc), 32'h0);

    // Random transfers against the model
    for (int i = 0; i < 24; i++) begin
      r.addr = $urandom;
      r.addr[15:12] = 4'($urandom_range(0, 7));
      r.wr    = 1'($urandom_range(0, 1));
      r.wdata = $urandom;
      r.wt    = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 17));
      r.rdata = $urandom;
      r.err   = 1'($urandom_range(0, 1));
      r.drop  = ($urandom_range(0, 3) == 0);
      model(r.addr, r.wr, r.wt, r.rdata, r.err, lat, d, e, t, ps);
      r.e_lat = lat; r.e_data = d; r.e_err = e; r.e_to = t; r.e_psel = ps;
      run_txn($sformatf("rnd%0d", i), r);
    end

    // Reset asserted mid-ACCESS clears every output at once
    run_txn("prerst", tbl[0]);
    S_PREADY = '0; S_PSLVERR = '0;
    @(negedge clk);
    M_PADDR = 32'h0000_0ABC; M_PWRITE = 1'b1; M_PWDATA = 32'h1357_9BDF;
    M_PSEL = 1'b1; M_PENABLE = 1'b0;
    @(negedge clk);
    M_PENABLE = 1'b1;
    @(negedge clk);
    chk("midrst in_access", 32'({S_PSEL, S_PENABLE}), 32'({4'b0001, 1'b1}));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst prdata", M_PRDATA, 32'h0);
    chk("midrst ctrl", 32'({M_PREADY, M_PSLVERR, S_PSEL, S_PENABLE, S_PWRITE, TIMEOUT_PULSE}), 32'h0);
    chk("midrst paddr", S_PADDR, 32'h0);
    chk("midrst pwdata", S_PWDATA, 32'h0);
    M_PSEL = 1'b0; M_PENABLE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r = '{32'h0000_0ABC, 1'b0, 32'h0, 0, 32'h600D_F00D, 1'b0, 1'b0, 3, 32'h600D_F00D, 1'b0, 1'b0, 4'b0001};
    run_txn("postrst", r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
